// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC select, sync-read imem latency absorption, IF/ID register
// Tracks the address whose data is on imem_instr and loads it into IF/ID unless stalled or flushed.

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q;
    logic        pend_valid;

    // Replaying pc_q while stalled (or before the first issue) keeps imem_instr valid for pc_q.
    always_comb begin
        imem_pc = pc_q;
        if (redirect_valid) begin
            imem_pc = {redirect_pc[31:2], 2'b00};
        end else if (pend_valid && !stall) begin
            imem_pc = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            pend_valid     <= 1'b0;
            if_id_instr    <= 32'd0;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            misalign_err   <= 1'b0;
            fetch_count    <= 32'd0;
        end else begin
            pc_q       <= imem_pc;
            pend_valid <= 1'b1;
            if (redirect_valid) begin
                // Flush only through the valid bit; a redirect overrides a simultaneous stall.
                if_id_valid <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else if (!stall) begin
                if_id_instr    <= imem_instr;
                if_id_pc       <= pc_q;
                if_id_pc_plus4 <= pc_q + 32'd4;
                if_id_valid    <= pend_valid;
                if (pend_valid) begin
                    fetch_count <= fetch_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch with a delivery-stream model

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr = 32'd0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h8C08_0000;
            32'h0000_0004: mem_word = 32'h8C09_0004;
            32'h0000_0008: mem_word = 32'h340B_0002;
            default:       mem_word = {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) imem_instr <= mem_word(imem_pc);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model: m_next is the next address to be delivered; m_warm means its data is already on imem_instr.
    logic [31:0] m_next;
    logic        m_warm;
    logic        m_valid;
    logic [31:0] m_count;
    logic        m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
        logic [31:0] exp_pc;
        @(negedge clk);
        reset = r;
        stall = s;
        redirect_valid = rd;
        redirect_pc = tgt;
        #1;
        if (!r) begin
            if (rd)           exp_pc = {tgt[31:2], 2'b00};
            else if (!m_warm) exp_pc = m_next;
            else if (s)       exp_pc = m_next;
            else              exp_pc = m_next + 32'd4;
            chk("imem_pc", imem_pc, exp_pc);
        end
        @(posedge clk);
        if (r) begin
            m_next = RESET_PC; m_warm = 1'b0; m_valid = 1'b0; m_count = 32'd0; m_mis = 1'b0;
        end else if (rd) begin
            m_valid = 1'b0;
            m_next = {tgt[31:2], 2'b00};
            m_warm = 1'b1;
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        end else if (s) begin
            m_warm = 1'b1;
        end else if (m_warm) begin
            sb.push_back('{pc: m_next, instr: mem_word(m_next)});
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
            m_next = m_next + 32'd4;
        end else begin
            m_valid = 1'b0;
            m_warm = 1'b1;
        end
        #1;
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        chk("fetch_count", fetch_count, m_count);
        if (r) begin
            chk("rst_instr", if_id_instr, 32'd0);
            chk("rst_pc", if_id_pc, 32'd0);
            chk("rst_pc4", if_id_pc_plus4, 32'd0);
        end
    endtask

    // Monitor: each new IF/ID load is popped and compared against the scoreboard.
    logic [31:0] last_count = 32'd0;
    always @(negedge clk) begin
        if (if_id_valid === 1'b1 && fetch_count !== last_count) begin
            if (sb.size() == 0) begin
                chk("unexpected_delivery_pc", if_id_pc, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deliv_pc", if_id_pc, e.pc);
                chk("deliv_instr", if_id_instr, e.instr);
                chk("deliv_pc4", if_id_pc_plus4, e.pc + 32'd4);
            end
        end
        last_count = fetch_count;
    end

    initial begin
        m_next = RESET_PC; m_warm = 1'b0; m_valid = 1'b0; m_count = 32'd0; m_mis = 1'b0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        // Sequential fetch then a 3-cycle stall holding pc 4.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        // Redirects: plain, with stall, misaligned, near the top of the address space.
        cycle(0, 0, 1, 32'h0000_001C);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 32'h0000_003C);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0022);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        // Mid-stream reset, then redirect in the first cycle after reset.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0100);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            logic        r, s, rd;
            logic [31:0] t;
            r  = ($urandom % 64) == 0;
            rd = ($urandom % 8) == 0;
            s  = ($urandom % 4) == 0;
            t  = $urandom;
            if (($urandom % 6) != 0) t[1:0] = 2'b00;
            cycle(r, s, rd, t);
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
